// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and widths for the sequential divider
package div_pkg;
  typedef enum logic {IDLE, CALC} state_t;
  localparam int DVD_W = 64;
  localparam int DVS_W = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (trial subtract, keep or restore)
module div_step
  import div_pkg::*;
(
  input  logic [DVS_W-1:0] i_p,
  input  logic             i_s_msb,
  input  logic [DVS_W-1:0] i_b,
  output logic [DVS_W-1:0] o_p,
  output logic             o_q
);
  logic [DVS_W:0] w_t;
  assign w_t = {i_p, i_s_msb} - {1'b0, i_b};
  assign o_q = !w_t[DVS_W];
  assign o_p = o_q ? w_t[DVS_W-1:0] : {i_p[DVS_W-2:0], i_s_msb};
endmodule

// File: rtl/div_seq.sv
// div_seq: signed 64/32 sequential restoring divider; DIV_EARLY_OUT_EN reports precheck errors after one cycle
module div_seq
  import div_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [DVD_W-1:0] dvdnd,
  input  logic [DVS_W-1:0] dvsor,
  input  logic             start,
  output logic [DVS_W-1:0] quot,
  output logic [DVS_W-1:0] remd,
  output logic             valid,
  output logic             busy,
  output logic             err
);
  state_t           r_state, w_state_nx;
  logic             r_start_bf, r_neg_q, r_neg_r, r_pre_err;
  logic [CNT_W-1:0] r_cnt;
  logic [DVS_W-1:0] r_p, r_s, r_b;
  logic [DVD_W-1:0] w_a;
  logic [DVS_W-1:0] w_b, w_p_nx, w_qmag;
  logic             w_q_bit, w_pre, w_rng, w_err, w_launch, w_done;
  assign w_a    = dvdnd[DVD_W-1] ? -dvdnd : dvdnd;
  assign w_b    = dvsor[DVS_W-1] ? -dvsor : dvsor;
  assign w_pre  = (w_b == '0) || (w_a[DVD_W-1:DVS_W] >= w_b);
  assign w_qmag = {r_s[DVS_W-2:0], w_q_bit};
  assign w_rng  = r_neg_q ? (w_qmag > 32'h8000_0000) : (w_qmag > 32'h7fff_ffff);
  assign w_err  = r_pre_err || w_rng;
  div_step u_step (
    .i_p    (r_p),
    .i_s_msb(r_s[DVS_W-1]),
    .i_b    (r_b),
    .o_p    (w_p_nx),
    .o_q    (w_q_bit)
  );
  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  // launch detection, completion and next state
  always_comb begin
    w_launch   = (r_state == IDLE) && start && !r_start_bf;
    w_done     = 1'b0;
    w_state_nx = r_state;
`ifdef DIV_EARLY_OUT_EN
    w_done = (r_state == CALC) && ((r_cnt == CNT_W'(ITER - 1)) || r_pre_err);
`else
    w_done = (r_state == CALC) && (r_cnt == CNT_W'(ITER - 1));
`endif
    if (w_launch) w_state_nx = CALC;
    if (w_done) w_state_nx = IDLE;
  end
  // operand capture, iteration and sign-fixed result write-back
  always_ff @(posedge clock) begin
    if (reset) begin
      r_start_bf <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_pre_err  <= 1'b0;
      r_cnt      <= '0;
      r_p        <= '0;
      r_s        <= '0;
      r_b        <= '0;
      quot       <= '0;
      remd       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_start_bf <= start;
      valid      <= w_done;
      if (w_launch) begin
        busy      <= 1'b1;
        r_cnt     <= '0;
        r_p       <= w_a[DVD_W-1:DVS_W];
        r_s       <= w_a[DVS_W-1:0];
        r_b       <= w_b;
        r_neg_q   <= dvdnd[DVD_W-1] ^ dvsor[DVS_W-1];
        r_neg_r   <= dvdnd[DVD_W-1];
        r_pre_err <= w_pre;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_p   <= w_p_nx;
        r_s   <= w_qmag;
      end
      if (w_done) begin
        busy <= 1'b0;
        err  <= w_err;
        quot <= w_err ? '0 : (r_neg_q ? -w_qmag : w_qmag);
        remd <= w_err ? '0 : (r_neg_r ? -w_p_nx : w_p_nx);
      end
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq
module tb_div_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] dvdnd = '0;
  logic [31:0] dvsor = '0;
  logic        start = 1'b0;
  logic [31:0] quot, remd;
  logic        valid, busy, err;
  int total = 0;
  int bad = 0;
  int lat0;
  int k;
  int nv;
  div_seq dut (
    .clock(clock),
    .reset(reset),
    .dvdnd(dvdnd),
    .dvsor(dvsor),
    .start(start),
    .quot (quot),
    .remd (remd),
    .valid(valid),
    .busy (busy),
    .err  (err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (valid !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask
  task automatic run(input string tag, input logic [63:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic ee, input int lat);
    int l;
    @(negedge clock);
    dvdnd = a;
    dvsor = b;
    start = 1'b1;
    @(negedge clock);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    wait_valid(l);
    chk({tag, " latency"}, 64'(l), 64'(lat));
    chk({tag, " quot"}, 64'(quot), 64'(eq));
    chk({tag, " remd"}, 64'(remd), 64'(er));
    chk({tag, " err"}, 64'(err), 64'(ee));
    chk({tag, " busy_done"}, 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clock);
    chk({tag, " valid_width"}, 64'(valid), 64'd0);
  endtask
  initial begin
`ifdef DIV_EARLY_OUT_EN
    lat0 = 1;
`else
    lat0 = 32;
`endif
    repeat (3) @(negedge clock);
    chk("rst quot", 64'(quot), 64'd0);
    chk("rst remd", 64'(remd), 64'd0);
    chk("rst valid", 64'(valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    run("pos", 64'd100, 32'd7, 32'h0000_000e, 32'h0000_0002, 1'b0, 32);
    run("negdvd", 64'hffff_ffff_ffff_ff9c, 32'd7, 32'hffff_fff2, 32'hffff_fffe, 1'b0, 32);
    run("product", 64'h3fff_ffff_0000_0001, 32'h7fff_ffff, 32'h7fff_ffff, 32'h0, 1'b0, 32);
    run("negbound", 64'hffff_ffff_8000_0000, 32'd1, 32'h8000_0000, 32'h0, 1'b0, 32);
    run("divzero", 64'd100, 32'd0, 32'h0, 32'h0, 1'b1, lat0);
    run("negdvs", 64'd100, 32'hffff_fff9, 32'hffff_fff2, 32'h0000_0002, 1'b0, 32);
    run("range", 64'hc000_0000_0000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 32);
    run("ovf", 64'h0000_0007_0000_0000, 32'd7, 32'h0, 32'h0, 1'b1, lat0);
    // start held high across valid: one result only
    dvdnd = 64'd1000;
    dvsor = 32'd3;
    start = 1'b1;
    @(negedge clock);
    wait_valid(k);
    chk("hold latency", 64'(k), 64'd32);
    chk("hold quot", 64'(quot), 64'd333);
    chk("hold remd", 64'(remd), 64'd1);
    nv = 0;
    repeat (40) begin
      @(negedge clock);
      if (valid) nv++;
    end
    chk("hold relaunch", 64'(nv), 64'd0);
    chk("hold busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clock);
    // toggling start while busy is ignored
    dvdnd = 64'd100;
    dvsor = 32'd7;
    start = 1'b1;
    @(negedge clock);
    k = 1;
    repeat (4) begin
      @(negedge clock);
      k++;
    end
    dvdnd = 64'd1000;
    dvsor = 32'd9;
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k += 4;
    nv = 0;
    while (valid !== 1'b1 && nv < 40) begin
      @(negedge clock);
      nv++;
    end
    chk("toggle latency", 64'(k + nv - 1), 64'd32);
    chk("toggle quot", 64'(quot), 64'h0e);
    chk("toggle remd", 64'(remd), 64'h02);
    repeat (40) @(negedge clock);
    chk("toggle no relaunch", 64'(busy), 64'd0);
    // reset mid-operation aborts without a result
    dvdnd = 64'hffff_ffff_ffff_ff9c;
    dvsor = 32'd7;
    start = 1'b1;
    @(negedge clock);
    repeat (9) @(negedge clock);
    chk("abort busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort quot", 64'(quot), 64'd0);
    chk("abort remd", 64'(remd), 64'd0);
    chk("abort busy0", 64'(busy), 64'd0);
    chk("abort valid", 64'(valid), 64'd0);
    chk("abort err", 64'(err), 64'd0);
    start = 1'b0;
    reset = 1'b0;
    nv = 0;
    repeat (40) begin
      @(negedge clock);
      if (valid) nv++;
    end
    chk("abort no valid", 64'(nv), 64'd0);
    run("after abort", 64'd100, 32'd7, 32'h0000_000e, 32'h0000_0002, 1'b0, 32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
